// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_pkg
// Purpose  : Shared types, constants and helpers for the clock-divider
//            controller and its counter core.
// Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

  // Controller states; explicit 2-bit encoding
  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  // Smallest ratio that still produces a two-phase output
  localparam int DIV_MIN = 2;

  // Widest ratio the helper below supports (CW must not exceed this)
  localparam int c_hw_max = 16;

  // High-phase length of an N-cycle period: ceil(N/2), one extra bit so that
  // N = 2^CW-1 cannot overflow the sum.
  function automatic logic [c_hw_max:0] hi_len(input logic [c_hw_max-1:0] n);
    logic [c_hw_max:0] w_sum;
    w_sum  = {1'b0, n} + {{c_hw_max{1'b0}}, 1'b1};
    hi_len = w_sum >> 1;
  endfunction

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_core.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_core
// Purpose  : Period counter, high-phase compare and registered clk_out/tick.
//            'run' is the controller's next-cycle run decision; 'wrap' flags
//            the last cycle of the current output period.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] ratio,
  input  logic          run,
  output logic          wrap,
  output logic          clk_out,
  output logic          tick
);

  logic [CW-1:0]     r_cnt;
  logic              r_active;
  logic              r_clk_out;
  logic              r_tick;

  logic              w_last;
  logic [CW-1:0]     w_cnt_inc;
  logic [c_hw_max:0] w_hi;
  logic              w_high_next;

  assign w_last      = (r_cnt == (ratio - CW'(1)));
  assign wrap        = r_active && w_last;
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_hi        = hi_len(c_hw_max'(ratio));
  assign w_high_next = ((c_hw_max + 1)'(w_cnt_inc) < w_hi);

  // Counter and output phase advance together so clk_out always matches cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_active  <= 1'b0;
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_active <= run;
      if (!run) begin
        r_cnt     <= '0;
        r_clk_out <= 1'b0;
        r_tick    <= 1'b0;
      end else if (!r_active || w_last) begin
        // New period: count 0 is always inside the high phase
        r_cnt     <= '0;
        r_clk_out <= 1'b1;
        r_tick    <= 1'b1;
      end else begin
        r_cnt     <= w_cnt_inc;
        r_clk_out <= w_high_next;
        r_tick    <= 1'b0;
      end
    end
  end

  assign clk_out = r_clk_out;
  assign tick    = r_tick;

endmodule : clkdiv_core
`default_nettype wire

// File: rtl/clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clkdiv_ctrl
// Purpose  : Run-time controller for the programmable clock divider. Holds
//            the active ratio, takes new ratios over a req/ack handshake and
//            applies them only at a period boundary; gates the output on/off
//            without runt pulses.
// Revision : 1.0 - initial release
// ============================================================================
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int CW      = 8,
  parameter int DIV_RST = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          div_req,
  input  logic [CW-1:0] div_val,
  output logic          div_ack,
  output logic          div_err,
  output logic          clk_out,
  output logic          tick,
  output logic          busy,
  output logic [CW-1:0] ratio
);

  localparam logic [CW-1:0] c_div_rst = CW'(DIV_RST);
  localparam logic [CW-1:0] c_div_min = CW'(DIV_MIN);

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_ratio, w_ratio_next;
  logic [CW-1:0] r_shadow, w_shadow_next;
  logic          r_ack, w_ack_next;
  logic          r_err, w_err_next;

  logic          w_req;
  logic          w_invalid;
  logic          w_wrap;
  logic          w_run;

  // A request is only looked at while no ack is outstanding
  assign w_req     = div_req && !r_ack;
  assign w_invalid = (div_val < c_div_min);
  assign w_run     = (w_state_next != STOP);

  // Controller registers: state, active ratio, shadow ratio, handshake pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= STOP;
      r_ratio  <= c_div_rst;
      r_shadow <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_ratio  <= w_ratio_next;
      r_shadow <= w_shadow_next;
      r_ack    <= w_ack_next;
      r_err    <= w_err_next;
    end
  end

  // Next-state, ratio update and handshake decisions
  always_comb begin
    w_state_next  = r_state;
    w_ratio_next  = r_ratio;
    w_shadow_next = r_shadow;
    w_ack_next    = 1'b0;
    w_err_next    = 1'b0;
    unique case (r_state)
      STOP: begin
        // Output is idle, so a valid ratio can be applied immediately
        if (w_req) begin
          w_ack_next = 1'b1;
          if (w_invalid) w_err_next   = 1'b1;
          else           w_ratio_next = div_val;
        end
        if (en) w_state_next = RUN;
      end
      RUN: begin
        if (w_req && w_invalid) begin
          w_ack_next = 1'b1;
          w_err_next = 1'b1;
        end
        if (w_wrap && !en) begin
          // Stopping at this boundary: no later boundary will come, so a
          // valid request arriving now is applied together with the stop.
          w_state_next = STOP;
          if (w_req && !w_invalid) begin
            w_ratio_next = div_val;
            w_ack_next   = 1'b1;
          end
        end else if (w_req && !w_invalid) begin
          // Even on the boundary cycle itself, the change waits one period
          w_shadow_next = div_val;
          w_state_next  = PEND;
        end
      end
      PEND: begin
        // The held request is the one pending; nothing else is sampled here
        if (w_wrap) begin
          w_ratio_next = r_shadow;
          w_ack_next   = 1'b1;
          w_state_next = en ? RUN : STOP;
        end
      end
      default: begin
        w_state_next = STOP;
      end
    endcase
  end

  clkdiv_core #(
    .CW      (CW)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .ratio   (r_ratio),
    .run     (w_run),
    .wrap    (w_wrap),
    .clk_out (clk_out),
    .tick    (tick)
  );

  assign div_ack = r_ack;
  assign div_err = r_err;
  assign busy    = (r_state == PEND);
  assign ratio   = r_ratio;

endmodule : clkdiv_ctrl
`default_nettype wire

// File: tb/tb_clkdiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clkdiv_ctrl
// Purpose  : Self-checking bench for clkdiv_ctrl. Each scenario queues
//            per-cycle stimulus with the expected outputs, then replays it
//            and compares every cycle on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clkdiv_ctrl;

  localparam int CW      = 8;
  localparam int DIV_RST = 3;

  typedef struct packed {
    logic          co;
    logic          tk;
    logic          ack;
    logic          err;
    logic          busy;
    logic [CW-1:0] ratio;
  } obs_t;

  typedef struct packed {
    logic          en;
    logic          req;
    logic [CW-1:0] val;
  } stim_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          en      = 1'b0;
  logic          div_req = 1'b0;
  logic [CW-1:0] div_val = '0;
  logic          div_ack;
  logic          div_err;
  logic          clk_out;
  logic          tick;
  logic          busy;
  logic [CW-1:0] ratio;

  obs_t  w_obs;
  stim_t stim_q[$];
  obs_t  exp_q[$];
  int    n_errors = 0;
  int    n_checks = 0;

  always #5 clk = ~clk;

  clkdiv_ctrl #(
    .CW      (CW),
    .DIV_RST (DIV_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy),
    .ratio   (ratio)
  );

  assign w_obs = {clk_out, tick, div_ack, div_err, busy, ratio};

  // Queue one cycle of stimulus together with the outputs it must produce
  task automatic push(input logic e, input logic r, input logic [CW-1:0] v,
                      input logic co, input logic tk, input logic ak,
                      input logic er, input logic bz, input logic [CW-1:0] rt);
    stim_t s;
    obs_t  x;
    s = {e, r, v};
    x = {co, tk, ak, er, bz, rt};
    stim_q.push_back(s);
    exp_q.push_back(x);
  endtask

  function automatic string fmt(input obs_t o);
    return $sformatf("clk_out=%b tick=%b ack=%b err=%b busy=%b ratio=%0d",
                     o.co, o.tk, o.ack, o.err, o.busy, o.ratio);
  endfunction

  task automatic test_reset();
    obs_t x;
    x = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(DIV_RST)};
    @(negedge clk);
    n_checks++;
    if (w_obs !== x) begin
      n_errors++;
      $display("FAIL reset_held got %s want %s", fmt(w_obs), fmt(x));
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_obs !== x) begin
      n_errors++;
      $display("FAIL reset_release got %s want %s", fmt(w_obs), fmt(x));
    end
  endtask

  task automatic test_run3();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    for (int i = 0; i < 9; i++)
      push(1'b1, 1'b0, '0, (i % 3) != 2, (i % 3) == 0, 1'b0, 1'b0, 1'b0, 8'd3);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL run3 cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_invalid();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    push(1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
    push(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    push(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    push(1'b1, 1'b1, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
    push(1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL invalid cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_change5();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    int    c;
    push(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    push(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
    for (int i = 1; i < 10; i++) begin
      c = i % 5;
      push(1'b1, 1'b0, '0, c < 3, c == 0, 1'b0, 1'b0, 1'b0, 8'd5);
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL change5 cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_boundary_req();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    push(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
    for (int c = 1; c < 5; c++)
      push(1'b1, 1'b1, 8'd4, c < 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd5);
    push(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
    for (int c = 1; c < 4; c++)
      push(1'b1, 1'b0, '0, c < 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL boundary_req cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_en_drop();
    stim_t        s;
    obs_t         x;
    int           cyc = 0;
    logic [14:0]  en_v = 15'b000011011000011;
    logic [14:0]  co_v = 15'b000110011000011;
    logic [14:0]  tk_v = 15'b000010001000001;
    for (int i = 0; i < 15; i++)
      push(en_v[i], 1'b0, '0, co_v[i], tk_v[i], 1'b0, 1'b0, 1'b0, 8'd4);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL en_drop cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_stop_req6();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    int    c;
    push(1'b0, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    push(1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd6);
    for (int i = 0; i < 12; i++) begin
      c = i % 6;
      push(1'b1, 1'b0, '0, c < 3, c == 0, 1'b0, 1'b0, 1'b0, 8'd6);
    end
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL stop_req6 cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_pend_en0();
    stim_t s;
    obs_t  x;
    int    cyc = 0;
    push(1'b1, 1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6);
    push(1'b1, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    for (int c = 2; c < 6; c++)
      push(1'b0, 1'b1, 8'd3, c < 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    push(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    push(1'b0, 1'b0, '0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL pend_en0 cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t s;
    obs_t  x;
    obs_t  r;
    int    cyc = 0;
    r = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CW'(DIV_RST)};
    push(1'b1, 1'b0, '0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
    push(1'b1, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    push(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL reset_mid_pre cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
    // Assert reset between edges: outputs must clear without a clock
    #2;
    rst_n = 1'b0; en = 1'b0; div_req = 1'b0; div_val = '0;
    #1;
    n_checks++;
    if (w_obs !== r) begin
      n_errors++;
      $display("FAIL reset_mid_async got %s want %s", fmt(w_obs), fmt(r));
    end
    @(negedge clk);
    n_checks++;
    if (w_obs !== r) begin
      n_errors++;
      $display("FAIL reset_mid_noack got %s want %s", fmt(w_obs), fmt(r));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      push(1'b1, 1'b0, '0, (i % 3) != 2, (i % 3) == 0, 1'b0, 1'b0, 1'b0, 8'd3);
    cyc = 0;
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      en = s.en; div_req = s.req; div_val = s.val;
      @(negedge clk);
      x = exp_q.pop_front();
      n_checks++;
      if (w_obs !== x) begin
        n_errors++;
        $display("FAIL reset_mid_post cyc%0d got %s want %s", cyc, fmt(w_obs), fmt(x));
      end
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_run3();
    test_invalid();
    test_change5();
    test_boundary_req();
    test_en_drop();
    test_stop_req6();
    test_pend_en0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_clkdiv_ctrl
`default_nettype wire

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
- Run-time controller for the programmable clock divider.
- Holds the active divide ratio and accepts new ratios through a req/ack handshake.
- Applies a new ratio only at an output-period boundary, so the output never produces runt pulses.
- Gates the divided output on/off glitch-free. Sits between the scan-chain config bits and the divider output pin.

Parameters:
- CW, 8, ratio/counter width in bits.
- DIV_RST, 3, ratio loaded at reset (2..2^CW-1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level; 1 = run the divided output, 0 = stop after the current period.
- div_req  in  1  ratio-change request; held high until div_ack.
- div_val  in  CW  requested ratio; stable while div_req is high.
- div_ack  out  1  one-cycle pulse: request consumed (applied or rejected).
- div_err  out  1  one-cycle pulse coincident with div_ack when div_val < 2.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse on each clk_out rising edge.
- busy  out  1  high while a valid request waits for a period boundary.
- ratio  out  CW  currently active ratio N.

Behaviour:
- Reset (async assert, sync release): state=STOP, cnt=0, N=DIV_RST, shadow=0, clk_out=0, tick=0, div_ack=0, div_err=0, busy=0.
- States: STOP, RUN, PEND.
- Counter cnt runs 0..N-1, wrapping to 0; width CW.
- Period boundary = RUN/PEND with cnt==N-1.
- HI = ceil(N/2) = (N+1)>>1, computed at CW+1 bits.
- clk_out registered, updated in the same edge as cnt: clk_out = (cnt < HI).
  - N=3 gives 110, N=4 gives 1100, N=5 gives 11100.
- tick registered: high in the cycle where cnt==0 in RUN/PEND.
- STOP -> RUN when en=1: next edge cnt=0, clk_out=1, tick=1 (1-cycle latency).
- In RUN/PEND with en=0: continue to the boundary, then go to STOP with clk_out=0 and cnt=0.
  - If en returns to 1 before the boundary, keep running with no disturbance.
- div_req sampled only when div_ack is low; the request must drop the cycle after ack.
- Invalid request (div_val<2), any state: next cycle div_ack=1 and div_err=1; N unchanged; state unchanged.
- Valid request in STOP: next cycle N=div_val and div_ack=1.
- Valid request in RUN: latch shadow=div_val, go to PEND, busy=1.
  - At the boundary: N<=shadow, cnt<=0, div_ack=1, busy=0, then RUN (or STOP if en=0).
  - The first period with the new N starts on the edge the ack is issued.
- Request arriving at the boundary cycle itself (RUN, cnt==N-1): latched to PEND; applied at the next boundary, not this one.
- div_req held during PEND is ignored; no second latch.
- Boundary with en=0 and PEND: ratio applied, ack issued, state=STOP.
- Reset mid-operation: immediate return to reset values; the pending request is discarded with no ack.
- div_val=N while running: still handshaked through PEND; no visible output change.

Decomposition:
- Shared package clkdiv_pkg holds:
  - state enum {STOP, RUN, PEND};
  - constant DIV_MIN=2;
  - function hi_len(N) returning (N+1)>>1.
- One sub-module, clkdiv_core: counter, HI compare, and clk_out/tick registers; inputs ratio and run; output wrap flag.
- The controller FSM and shadow register live in clkdiv_ctrl.

Test Plan:
- Reset, then en=1, N=3, observe 9 cycles → clk_out = 1,1,0,1,1,0,1,1,0; tick at cycles 0,3,6; ratio=3.
- Running N=3, div_req with div_val=5 at cnt=1 → busy=1; ack at the next cnt=0; then clk_out = 1,1,1,0,0 repeating; ratio=5.
- div_req with div_val=1 while running → next-cycle div_ack=1 and div_err=1; ratio stays 3; waveform unchanged.
- N=4, en dropped at cnt=1 → pattern completes 1,1,0,0 (cnt 0..3), then clk_out=0 and state STOP; en re-asserted → clk_out=1 after 1 cycle.
- STOP, div_req with div_val=6 → ack in 1 cycle; en=1 → 111000 repeating.
- rst_n low mid-PEND (N=3 to 7 pending) → clk_out=0, ratio=DIV_RST, busy=0, no ack; after release, en=1 gives a ratio-3 waveform.
